// File: rtl/pipe_skid_reg.sv
// Pipeline register stage with a valid/ready handshake and a 2-entry skid buffer.
// in_ready, out_valid and count are flops, so a downstream stall reaches
// upstream only through a register.
module pipe_skid_reg #(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RST_VAL   = {DATA_WIDTH{1'b0}},
    parameter bit                   CLR_DATA   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            count
);

    localparam int unsigned CNT_W = 2;

    // The encoding is the number of entries held.
    typedef enum logic [CNT_W-1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] main_data;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  main_ld;
    logic                  main_from_skid;
    logic                  skid_ld;
    logic                  clr_data;
    logic                  in_fire;
    logic                  out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign out_data = main_data;

    // Next-state and data-register load enables.
    always_comb begin
        state_nxt      = state;
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        clr_data       = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
            clr_data  = CLR_DATA;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_ld   = 1'b1;
                        state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_ld = 1'b1;
                    end else if (in_fire) begin
                        skid_ld   = 1'b1;
                        state_nxt = FULL;
                    end else if (out_fire) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_ld        = 1'b1;
                        main_from_skid = 1'b1;
                        state_nxt      = ONE;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // State register plus handshake flops decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            count     <= '0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt != FULL);
            out_valid <= (state_nxt != EMPTY);
            count     <= CNT_W'(state_nxt);
        end
    end

    // Main and skid data registers; written only on the listed transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data <= RST_VAL;
            skid_data <= RST_VAL;
        end else if (clr_data) begin
            main_data <= RST_VAL;
            skid_data <= RST_VAL;
        end else begin
            if (main_ld) begin
                main_data <= main_from_skid ? skid_data : in_data;
            end
            if (skid_ld) begin
                skid_data <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and randomised checks of pipe_skid_reg: instances with CLR_DATA=1,
// CLR_DATA=0 (sharing stimulus) and an 8-bit instance with a non-zero reset value.
module tb_pipe_skid_reg;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        a_in_ready, a_out_valid;
    logic [31:0] a_out_data;
    logic [1:0]  a_count;
    logic        b_in_ready, b_out_valid;
    logic [31:0] b_out_data;
    logic [1:0]  b_count;

    logic        c_flush, c_in_valid, c_out_ready;
    logic [7:0]  c_in_data;
    logic        c_in_ready, c_out_valid;
    logic [7:0]  c_out_data;
    logic [1:0]  c_count;

    int checks = 0;
    int errors = 0;

    pipe_skid_reg #(.DATA_WIDTH(32), .RST_VAL(32'h0), .CLR_DATA(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .count(a_count)
    );

    pipe_skid_reg #(.DATA_WIDTH(32), .RST_VAL(32'h0), .CLR_DATA(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .count(b_count)
    );

    pipe_skid_reg #(.DATA_WIDTH(8), .RST_VAL(8'h5A), .CLR_DATA(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .flush(c_flush),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .count(c_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it on mismatch.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] q[$];
    logic        m_in_fire, m_out_fire;

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        c_flush = 1'b0; c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b0;
        #12;
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_in_ready",  32'(a_in_ready),  32'd1);
        check("rst_count",     32'(a_count),     32'd0);
        check("rst_out_data",  a_out_data,       32'h0);
        check("rst_c_data",    32'(c_out_data),  32'h5A);
        rst_n = 1'b1;
        tick();

        // Streaming at full throughput.
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = 32'(i);
            tick();
            check("stream_valid", 32'(a_out_valid), 32'd1);
            check("stream_data",  a_out_data,       32'(i));
            check("stream_count", 32'(a_count),     32'd1);
            check("stream_ready", 32'(a_in_ready),  32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_drain_count", 32'(a_count), 32'd0);
        check("stream_drain_valid", 32'(a_out_valid), 32'd0);

        // Backpressure fills the skid; 0xC is refused while full.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
        tick();
        check("bp_one_count", 32'(a_count), 32'd1);
        in_data = 32'hB;
        tick();
        check("bp_full_count", 32'(a_count), 32'd2);
        check("bp_full_ready", 32'(a_in_ready), 32'd0);
        check("bp_full_data",  a_out_data, 32'hA);
        in_data = 32'hC;
        tick();
        check("bp_hold_count", 32'(a_count), 32'd2);
        check("bp_hold_data",  a_out_data, 32'hA);
        out_ready = 1'b1;
        tick();
        check("drain_b_data",  a_out_data, 32'hB);
        check("drain_b_count", 32'(a_count), 32'd1);
        tick();
        check("drain_c_data",  a_out_data, 32'hC);
        check("drain_c_count", 32'(a_count), 32'd1);
        in_valid = 1'b0;
        tick();
        check("drain_end_count", 32'(a_count), 32'd0);

        // Flush from FULL with a competing input.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
        tick();
        in_data = 32'h22;
        tick();
        check("fl_pre_count", 32'(a_count), 32'd2);
        flush = 1'b1; in_data = 32'h33;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_count",     32'(a_count),     32'd0);
        check("fl_valid",     32'(a_out_valid), 32'd0);
        check("fl_ready",     32'(a_in_ready),  32'd1);
        check("fl_clr_data",  a_out_data,       32'h0);
        check("fl_hold_data", b_out_data,       32'h11);
        check("fl_b_count",   32'(b_count),     32'd0);
        out_ready = 1'b1;
        tick();
        tick();
        check("fl_no_33_valid", 32'(a_out_valid), 32'd0);
        check("fl_no_33_b_data", b_out_data, 32'h11);

        // Random handshake against a FIFO model.
        q.delete();
        for (int cyc = 0; cyc < 1000; cyc++) begin
            check("rnd_count", 32'(a_count), 32'(q.size()));
            check("rnd_valid", 32'(a_out_valid), 32'(q.size() != 0));
            check("rnd_ready", 32'(a_in_ready), 32'(q.size() != 2));
            if (q.size() != 0) begin
                check("rnd_data_a", a_out_data, q[0]);
                check("rnd_data_b", b_out_data, q[0]);
            end
            in_valid  = 1'($urandom_range(1));
            out_ready = 1'($urandom_range(1));
            in_data   = $urandom;
            m_in_fire  = in_valid && (q.size() != 2);
            m_out_fire = out_ready && (q.size() != 0);
            tick();
            if (m_out_fire) void'(q.pop_front());
            if (m_in_fire) q.push_back(in_data);
        end

        // Async reset mid-cycle while FULL.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h44;
        tick();
        in_data = 32'h55;
        tick();
        in_valid = 1'b0;
        check("ar_pre_count", 32'(a_count), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(a_out_valid), 32'd0);
        check("ar_ready", 32'(a_in_ready),  32'd1);
        check("ar_count", 32'(a_count),     32'd0);
        check("ar_data",  a_out_data,       32'h0);
        check("ar_data_b", b_out_data,      32'h0);
        #2 rst_n = 1'b1;
        tick();
        check("ar_after_count", 32'(a_count), 32'd0);

        // 8-bit instance with RST_VAL 0x5A.
        check("c_rst_data", 32'(c_out_data), 32'h5A);
        c_in_valid = 1'b1; c_in_data = 8'hFF; c_out_ready = 1'b1;
        tick();
        c_in_valid = 1'b0;
        check("c_ff_data",  32'(c_out_data),  32'hFF);
        check("c_ff_valid", 32'(c_out_valid), 32'd1);
        tick();
        check("c_end_count", 32'(c_count), 32'd0);
        check("c_end_data",  32'(c_out_data), 32'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
